uart_stim_tx: RTL and testbench

UART_STIM_TX -- requirements
Module: uart_stim_tx

---
 rtl/uart_stim_tx.sv | 157 +++++++++++++++
 tb/tb_uart_stim_tx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_stim_tx.sv
// UART transmitter with a transmit FIFO. Frames are start, data (LSB first),
// optional parity and stop bits, followed by an optional forced idle gap.
module uart_stim_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8,
  parameter int GAP_CLKS     = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DATA_BITS-1:0]          in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [15:0]   BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [19:0]   GAP_LAST  = (GAP_CLKS > 0) ? 20'(GAP_CLKS - 1) : 20'd0;
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} state_e;

  state_e                 state_q, state_d;
  logic                   txd_q, txd_d;
  logic [15:0]            bit_cnt_q, bit_cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic [19:0]            gap_cnt_q, gap_cnt_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic                   push, pop, bit_end;

  // in_ready is forced high while in reset even though pushes are blocked then
  assign in_ready   = !resetn || (count_q != FULL);
  assign push       = resetn && in_valid && (count_q != FULL);
  assign pop        = (state_q == IDLE) && (count_q != '0);
  assign bit_end    = (bit_cnt_q == '0);
  assign txd        = txd_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    bit_cnt_d  = bit_cnt_q;
    idx_d      = idx_q;
    gap_cnt_d  = gap_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: if (pop) begin
        state_d   = START;
        txd_d     = 1'b0;
        bit_cnt_d = BIT_LAST;
        shreg_d   = mem_q[rd_ptr_q];
        par_d     = (^mem_q[rd_ptr_q]) ^ (PARITY == 1);
      end
      START: if (!bit_end) bit_cnt_d = bit_cnt_q - 16'd1;
      else begin
        state_d   = DATA;
        txd_d     = shreg_q[0];
        bit_cnt_d = BIT_LAST;
        idx_d     = '0;
      end
      DATA: if (!bit_end) bit_cnt_d = bit_cnt_q - 16'd1;
      else begin
        bit_cnt_d = BIT_LAST;
        if (idx_q == DATA_LAST) begin
          idx_d = '0;
          if (PARITY != 0) begin
            state_d = PAR;
            txd_d   = par_q;
          end else begin
            state_d = STOP;
            txd_d   = 1'b1;
          end
        end else begin
          // txd takes the next bit now; the register shifts in the same edge
          idx_d   = idx_q + 4'd1;
          shreg_d = shreg_q >> 1;
          txd_d   = shreg_q[1];
        end
      end
      PAR: if (!bit_end) bit_cnt_d = bit_cnt_q - 16'd1;
      else begin
        state_d   = STOP;
        txd_d     = 1'b1;
        bit_cnt_d = BIT_LAST;
        idx_d     = '0;
      end
      STOP: if (!bit_end) bit_cnt_d = bit_cnt_q - 16'd1;
      else if (idx_q == STOP_LAST) begin
        frame_done = 1'b1;
        idx_d      = '0;
        if (GAP_CLKS == 0) state_d = IDLE;
        else begin
          state_d   = GAP;
          gap_cnt_d = GAP_LAST;
        end
      end else begin
        idx_d     = idx_q + 4'd1;
        bit_cnt_d = BIT_LAST;
      end
      GAP: if (gap_cnt_q == '0) state_d = IDLE;
           else gap_cnt_d = gap_cnt_q - 20'd1;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      txd_q     <= 1'b1;
      bit_cnt_q <= '0;
      idx_q     <= '0;
      gap_cnt_q <= '0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      gap_cnt_q <= gap_cnt_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end
endmodule

// File: tb/tb_uart_stim_tx.sv
// Directed bench for uart_stim_tx: four instances (default, even parity,
// odd parity, 2 stop bits with 4000-cycle gap) checked cycle-exactly.
module tb_uart_stim_tx;
  localparam int CPB = 217;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;

  logic       resetn_a     [4];
  logic [7:0] in_data_a    [4];
  logic       in_valid_a   [4];
  logic       in_ready_a   [4];
  logic       txd_a        [4];
  logic       busy_a       [4];
  logic [3:0] fifo_count_a [4];
  logic       frame_done_a [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_stim_tx u0 (
    .clk(clk), .resetn(resetn_a[0]), .in_data(in_data_a[0]), .in_valid(in_valid_a[0]),
    .in_ready(in_ready_a[0]), .txd(txd_a[0]), .busy(busy_a[0]),
    .fifo_count(fifo_count_a[0]), .frame_done(frame_done_a[0]));
  uart_stim_tx #(.PARITY(2)) u1 (
    .clk(clk), .resetn(resetn_a[1]), .in_data(in_data_a[1]), .in_valid(in_valid_a[1]),
    .in_ready(in_ready_a[1]), .txd(txd_a[1]), .busy(busy_a[1]),
    .fifo_count(fifo_count_a[1]), .frame_done(frame_done_a[1]));
  uart_stim_tx #(.PARITY(1)) u2 (
    .clk(clk), .resetn(resetn_a[2]), .in_data(in_data_a[2]), .in_valid(in_valid_a[2]),
    .in_ready(in_ready_a[2]), .txd(txd_a[2]), .busy(busy_a[2]),
    .fifo_count(fifo_count_a[2]), .frame_done(frame_done_a[2]));
  uart_stim_tx #(.GAP_CLKS(4000), .STOP_BITS(2)) u3 (
    .clk(clk), .resetn(resetn_a[3]), .in_data(in_data_a[3]), .in_valid(in_valid_a[3]),
    .in_ready(in_ready_a[3]), .txd(txd_a[3]), .busy(busy_a[3]),
    .fifo_count(fifo_count_a[3]), .frame_done(frame_done_a[3]));

  // Frame bits in send order (bit 0 = start) for 8N1.
  function automatic logic [11:0] mk10(input logic [7:0] d);
    return {2'b00, 1'b1, d, 1'b0};
  endfunction

  task automatic push(input int sel, input logic [7:0] d);
    in_data_a[sel]  = d;
    in_valid_a[sel] = 1'b1;
    @(negedge clk);
    in_valid_a[sel] = 1'b0;
    in_data_a[sel]  = 8'hFF;
  endtask

  // Waits for a start bit, then checks every cycle of every bit plus frame_done.
  // Returns the posedge number of the start edge; ends on the frame's last cycle.
  task automatic frame_chk(input int sel, input logic [11:0] vec, input int nbits,
                           input string nm, output int t0);
    int n;
    logic fd_bad;
    int fd_k;
    n = 0; t0 = -1; fd_bad = 1'b0; fd_k = -1;
    while (txd_a[sel] !== 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (txd_a[sel] !== 1'b0) begin
      $display("FAIL %s start: no start bit within %0d cycles, txd=%b", nm, n, txd_a[sel]);
      return;
    end
    passes++;
    t0 = cyc;
    for (int b = 0; b < nbits; b++) begin
      logic bad;
      logic got;
      int   bad_c;
      bad = 1'b0; got = vec[b]; bad_c = -1;
      for (int c = 0; c < CPB; c++) begin
        if (txd_a[sel] !== vec[b] && !bad) begin
          bad = 1'b1; got = txd_a[sel]; bad_c = c;
        end
        if (frame_done_a[sel] !== ((b == nbits-1) && (c == CPB-1)) && !fd_bad) begin
          fd_bad = 1'b1; fd_k = b*CPB + c;
        end
        if (!(b == nbits-1 && c == CPB-1)) @(negedge clk);
      end
      checks++;
      if (bad) $display("FAIL %s bit%0d: txd=%b at cycle %0d of bit, expected %b",
                        nm, b, got, bad_c, vec[b]);
      else passes++;
    end
    checks++;
    if (fd_bad) $display("FAIL %s frame_done: wrong at frame cycle %0d, expected only at %0d",
                         nm, fd_k, nbits*CPB-1);
    else passes++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      resetn_a[i] = 1'b0; in_valid_a[i] = 1'b0; in_data_a[i] = 8'h00;
    end
    in_valid_a[0] = 1'b1; in_data_a[0] = 8'h77;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txd_a[i] !== 1'b1 || busy_a[i] !== 1'b0 || fifo_count_a[i] !== 4'd0 ||
          frame_done_a[i] !== 1'b0 || in_ready_a[i] !== 1'b1)
        $display("FAIL reset_state[%0d]: txd=%b busy=%b cnt=%0d fd=%b rdy=%b, expected 1 0 0 0 1",
                 i, txd_a[i], busy_a[i], fifo_count_a[i], frame_done_a[i], in_ready_a[i]);
      else passes++;
    end
    for (int i = 0; i < 4; i++) resetn_a[i] = 1'b1;
    in_valid_a[0] = 1'b0;
    begin
      logic bad;
      bad = 1'b0;
      repeat (300) begin
        @(negedge clk);
        if (txd_a[0] !== 1'b1 || fifo_count_a[0] !== 4'd0) bad = 1'b1;
      end
      checks++;
      if (bad) $display("FAIL reset_push_blocked: activity after reset, expected idle and count 0");
      else passes++;
    end
  endtask

  task automatic test_basic();
    int t0;
    push(0, 8'h34);
    checks++;
    if (fifo_count_a[0] !== 4'd1 || busy_a[0] !== 1'b0)
      $display("FAIL basic_enqueue: cnt=%0d busy=%b, expected 1 0", fifo_count_a[0], busy_a[0]);
    else passes++;
    frame_chk(0, 12'h268, 10, "basic", t0);
    @(negedge clk);
    checks++;
    if (busy_a[0] !== 1'b0 || txd_a[0] !== 1'b1 || fifo_count_a[0] !== 4'd0)
      $display("FAIL basic_end: busy=%b txd=%b cnt=%0d, expected 0 1 0",
               busy_a[0], txd_a[0], fifo_count_a[0]);
    else passes++;
  endtask

  task automatic test_simul_push_pop();
    int t0, t1;
    @(negedge clk);
    in_data_a[0] = 8'h55; in_valid_a[0] = 1'b1;
    @(negedge clk);
    in_data_a[0] = 8'h66;
    @(negedge clk);
    in_valid_a[0] = 1'b0; in_data_a[0] = 8'hFF;
    checks++;
    if (fifo_count_a[0] !== 4'd1 || busy_a[0] !== 1'b1)
      $display("FAIL simul_count: cnt=%0d busy=%b, expected 1 1", fifo_count_a[0], busy_a[0]);
    else passes++;
    frame_chk(0, mk10(8'h55), 10, "simul_f1", t0);
    frame_chk(0, mk10(8'h66), 10, "simul_f2", t1);
    checks++;
    if (t1 - (t0 + 10*CPB) !== 1)
      $display("FAIL simul_b2b: stop-end to start %0d cycles, expected 1", t1 - (t0 + 10*CPB));
    else passes++;
  endtask

  task automatic test_full_wrap();
    logic [7:0] exp_q [12];
    int t0, tp;
    exp_q[0] = 8'hA0;
    for (int i = 0; i < 8; i++) exp_q[1+i] = 8'hB0 + 8'(i);
    exp_q[9] = 8'hC0; exp_q[10] = 8'hC1; exp_q[11] = 8'hC2;
    @(negedge clk);
    push(0, 8'hA0);
    fork
      frame_chk(0, mk10(exp_q[0]), 10, "wrap_f0", tp);
      begin
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
          in_data_a[0] = 8'hB0 + 8'(i); in_valid_a[0] = 1'b1;
          if (i == 8) begin
            checks++;
            if (fifo_count_a[0] !== 4'd8 || in_ready_a[0] !== 1'b0)
              $display("FAIL full_flag: cnt=%0d rdy=%b, expected 8 0",
                       fifo_count_a[0], in_ready_a[0]);
            else passes++;
          end
          @(negedge clk);
        end
        in_valid_a[0] = 1'b0; in_data_a[0] = 8'hFF;
        checks++;
        if (fifo_count_a[0] !== 4'd8)
          $display("FAIL full_reject: cnt=%0d after 9th push, expected 8", fifo_count_a[0]);
        else passes++;
      end
    join
    for (int i = 1; i < 9; i++) begin
      frame_chk(0, mk10(exp_q[i]), 10, $sformatf("wrap_f%0d", i), t0);
      checks++;
      if (t0 - (tp + 10*CPB) !== 1)
        $display("FAIL wrap_b2b%0d: gap %0d, expected 1", i, t0 - (tp + 10*CPB));
      else passes++;
      tp = t0;
    end
    @(negedge clk);
    checks++;
    if (fifo_count_a[0] !== 4'd0 || busy_a[0] !== 1'b0)
      $display("FAIL wrap_drained: cnt=%0d busy=%b, expected 0 0", fifo_count_a[0], busy_a[0]);
    else passes++;
    fork
      for (int i = 9; i < 12; i++)
        frame_chk(0, mk10(exp_q[i]), 10, $sformatf("wrap_f%0d", i), t0);
      begin
        push(0, 8'hC0);
        push(0, 8'hC1);
        push(0, 8'hC2);
      end
    join
  endtask

  task automatic test_reset_mid();
    int n;
    logic bad;
    @(negedge clk);
    push(0, 8'h34);
    push(0, 8'h2A);
    n = 0;
    while (txd_a[0] !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (txd_a[0] !== 1'b0) $display("FAIL rstmid_start: no start bit, txd=%b", txd_a[0]);
    else passes++;
    repeat (4*CPB + 100) @(negedge clk);
    resetn_a[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (txd_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || fifo_count_a[0] !== 4'd0)
      $display("FAIL rstmid_abort: txd=%b busy=%b cnt=%0d, expected 1 0 0",
               txd_a[0], busy_a[0], fifo_count_a[0]);
    else passes++;
    resetn_a[0] = 1'b1;
    bad = 1'b0;
    repeat (3000) begin
      @(negedge clk);
      if (txd_a[0] !== 1'b1 || busy_a[0] !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL rstmid_quiet: frame activity after reset release, expected none");
    else passes++;
  endtask

  task automatic test_parity();
    int t0;
    push(1, 8'h2A);
    frame_chk(1, 12'h654, 11, "even_par", t0);
    push(2, 8'h2A);
    frame_chk(2, 12'h454, 11, "odd_par", t0);
  endtask

  task automatic test_gap();
    int ta, tb;
    push(3, 8'h34);
    push(3, 8'h2A);
    frame_chk(3, 12'h668, 11, "gap_f1", ta);
    repeat (100) @(negedge clk);
    checks++;
    if (busy_a[3] !== 1'b1 || txd_a[3] !== 1'b1)
      $display("FAIL gap_state: busy=%b txd=%b, expected 1 1", busy_a[3], txd_a[3]);
    else passes++;
    frame_chk(3, 12'h654, 11, "gap_f2", tb);
    checks++;
    if (tb - (ta + 11*CPB) !== 4001)
      $display("FAIL gap_len: stop-end to start %0d cycles, expected 4001", tb - (ta + 11*CPB));
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simul_push_pop();
    test_full_wrap();
    test_reset_mid();
    test_parity();
    test_gap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
